// File: rtl/sqrt_pipe_param_if.sv
// Operand and result valid/ready channels of the pipelined square-root unit.
// The master side is the producer/consumer; the slave side is the unit.
interface sqrt_pipe_param_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned ROOT_WIDTH = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] valor_i;
  logic                  round_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [ROOT_WIDTH-1:0] root_o;
  logic [ROOT_WIDTH:0]   rem_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    output valor_i, round_i, valid_i, ready_i,
    input  ready_o, root_o, rem_o, valid_o
  );

  modport slave (
    input  valor_i, round_i, valid_i, ready_i,
    output ready_o, root_o, rem_o, valid_o
  );
endinterface

// File: rtl/sqrt_pipe_param.sv
// Fully pipelined unsigned integer square root, one root bit per stage,
// with remainder output, optional round-to-nearest and global backpressure.
module sqrt_pipe_param #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  sqrt_pipe_param_if.slave  bus
);

  localparam int unsigned ROOT_WIDTH = DATA_WIDTH / 2;
  localparam int unsigned REM_WIDTH  = ROOT_WIDTH + 2;
  localparam int unsigned INC_WIDTH  = ROOT_WIDTH + 1;
  localparam int unsigned LAST       = ROOT_WIDTH - 1;

  // Stage registers; operand bits are only needed by stages that still have work left.
  logic [ROOT_WIDTH-1:0] valid_q;
  logic [ROOT_WIDTH-1:0] round_q;
  logic [ROOT_WIDTH-1:0] q_q [ROOT_WIDTH];
  logic [REM_WIDTH-1:0]  r_q [ROOT_WIDTH];
  logic [DATA_WIDTH-1:0] d_q [ROOT_WIDTH-1];

  // Per-stage combinational inputs and step results.
  logic [ROOT_WIDTH-1:0] q_in  [ROOT_WIDTH];
  logic [REM_WIDTH-1:0]  r_in  [ROOT_WIDTH];
  logic [DATA_WIDTH-1:0] d_in  [ROOT_WIDTH];
  logic [REM_WIDTH-1:0]  r_sh  [ROOT_WIDTH];
  logic [REM_WIDTH-1:0]  t_sub [ROOT_WIDTH];
  logic [ROOT_WIDTH-1:0] q_nxt [ROOT_WIDTH];
  logic [REM_WIDTH-1:0]  r_nxt [ROOT_WIDTH];
  logic [DATA_WIDTH-1:0] d_nxt [ROOT_WIDTH];

  logic                  advance;
  logic [ROOT_WIDTH-1:0] q_last;
  logic [REM_WIDTH-1:0]  r_last;
  logic [INC_WIDTH-1:0]  q_inc;
  logic                  round_up;
  logic [ROOT_WIDTH-1:0] root_c;

  assign advance     = !valid_q[LAST] || bus.ready_i;
  assign bus.ready_o = advance;
  assign bus.valid_o = valid_q[LAST];

  // Restoring digit recurrence, one step per stage.
  always_comb begin
    for (int s = 0; s < ROOT_WIDTH; s++) begin
      q_in[s]  = '0;
      r_in[s]  = '0;
      d_in[s]  = '0;
      r_sh[s]  = '0;
      t_sub[s] = '0;
      q_nxt[s] = '0;
      r_nxt[s] = '0;
      d_nxt[s] = '0;
    end
    d_in[0] = bus.valor_i;
    for (int s = 1; s < ROOT_WIDTH; s++) begin
      q_in[s] = q_q[s-1];
      r_in[s] = r_q[s-1];
      d_in[s] = d_q[s-1];
    end
    for (int s = 0; s < ROOT_WIDTH; s++) begin
      r_sh[s]  = (r_in[s] << 2) | REM_WIDTH'(d_in[s][DATA_WIDTH-1 -: 2]);
      t_sub[s] = {q_in[s], 2'b01};
      d_nxt[s] = d_in[s] << 2;
      if (r_sh[s] >= t_sub[s]) begin
        r_nxt[s] = r_sh[s] - t_sub[s];
        q_nxt[s] = {q_in[s][ROOT_WIDTH-2:0], 1'b1};
      end else begin
        r_nxt[s] = r_sh[s];
        q_nxt[s] = {q_in[s][ROOT_WIDTH-2:0], 1'b0};
      end
    end
  end

  // Whole pipeline advances or holds together; a non-accepting advance inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      round_q <= '0;
      for (int s = 0; s < ROOT_WIDTH; s++) begin
        q_q[s] <= '0;
        r_q[s] <= '0;
      end
      for (int s = 0; s < ROOT_WIDTH - 1; s++) begin
        d_q[s] <= '0;
      end
    end else if (advance) begin
      valid_q <= {valid_q[ROOT_WIDTH-2:0], bus.valid_i};
      round_q <= {round_q[ROOT_WIDTH-2:0], bus.round_i};
      for (int s = 0; s < ROOT_WIDTH; s++) begin
        q_q[s] <= q_nxt[s];
        r_q[s] <= r_nxt[s];
      end
      for (int s = 0; s < ROOT_WIDTH - 1; s++) begin
        d_q[s] <= d_nxt[s];
      end
    end
  end

  // Rounding: the root rounds up when the floor remainder exceeds the floor root.
  always_comb begin
    q_last   = q_q[LAST];
    r_last   = r_q[LAST];
    q_inc    = {1'b0, q_last} + INC_WIDTH'(1);
    round_up = round_q[LAST] && (r_last > {2'b00, q_last});
    root_c   = q_last;
    if (round_up) begin
      root_c = q_inc[ROOT_WIDTH] ? '1 : q_inc[ROOT_WIDTH-1:0];
    end
  end

  // Bubble contents are masked so only valid results are ever visible.
  assign bus.root_o = bus.valid_o ? root_c : '0;
  assign bus.rem_o  = bus.valid_o ? r_last[ROOT_WIDTH:0] : '0;

endmodule

// File: tb/tb_sqrt_pipe_param.sv
// Bench for sqrt_pipe_param: isqrt reference model with an in-order scoreboard,
// plus directed vectors for latency, rounding, reset flush and 32-bit corners.
module tb_sqrt_pipe_param;

  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [7:0] root;
    logic [8:0] rem;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt_pipe_param_if #(.DATA_WIDTH(DW)) bus ();
  sqrt_pipe_param_if #(.DATA_WIDTH(32)) bus32 ();

  sqrt_pipe_param #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  sqrt_pipe_param #(.DATA_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: largest x with x*x <= v; round up when v - x*x > x.
  function automatic res_t model(input logic [15:0] v, input logic rnd);
    int unsigned x;
    int unsigned r;
    res_t res;
    x = 0;
    while ((x + 1) * (x + 1) <= 32'(v)) x++;
    r = 32'(v) - x * x;
    res.rem = 9'(r);
    if (rnd && r > x) x = x + 1;
    if (x > 255) x = 255;
    res.root = 8'(x);
    return res;
  endfunction

  // Scoreboard: push on accept, pop on transfer, all sampled at the falling edge.
  logic prev_hold = 1'b0;
  res_t prev_out;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.valid_o, 1);
        chk("hold_root", bus.root_o, prev_out.root);
        chk("hold_rem", bus.rem_o, prev_out.rem);
      end
      chk("ready_o", bus.ready_o, !(bus.valid_o && !bus.ready_i));
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", bus.valid_o, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("model_root", bus.root_o, e.root);
          chk("model_rem", bus.rem_o, e.rem);
          n_out++;
        end
      end
      if (bus.valid_i && bus.ready_o) exp_q.push_back(model(bus.valor_i, bus.round_i));
      prev_hold     = bus.valid_o && !bus.ready_i;
      prev_out.root = bus.root_o;
      prev_out.rem  = bus.rem_o;
    end
  end

  task automatic single(input logic [15:0] v, input logic rnd,
                        input logic [7:0] er, input logic [8:0] em);
    int n;
    @(posedge clk); #1;
    bus.valor_i = v;
    bus.round_i = rnd;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (bus.valid_o) break;
      @(posedge clk);
      n++;
    end
    chk("latency16", n, 8);
    chk("root_literal", bus.root_o, er);
    chk("rem_literal", bus.rem_o, em);
  endtask

  task automatic single32(input logic [31:0] v, input logic [15:0] er, input logic [16:0] em);
    int n;
    @(posedge clk); #1;
    bus32.valor_i = v;
    bus32.round_i = 1'b0;
    bus32.valid_i = 1'b1;
    @(posedge clk); #1;
    bus32.valid_i = 1'b0;
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (bus32.valid_o) break;
      @(posedge clk);
      n++;
    end
    chk("latency32", n, 16);
    chk("root32", bus32.root_o, er);
    chk("rem32", bus32.rem_o, em);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int sent;
    int waitc;
    logic acc;

    bus.valor_i = '0;   bus.round_i = 1'b0;   bus.valid_i = 1'b0;   bus.ready_i = 1'b1;
    bus32.valor_i = '0; bus32.round_i = 1'b0; bus32.valid_i = 1'b0; bus32.ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid_o", bus.valid_o, 0);
    chk("reset_ready_o", bus.ready_o, 1);
    chk("reset_root_o", bus.root_o, 0);
    chk("reset_rem_o", bus.rem_o, 0);
    chk("reset_valid32", bus32.valid_o, 0);

    chk("pin_model_20", model(16'd20, 1'b0), {8'd4, 9'd4});
    chk("pin_model_21r", model(16'd21, 1'b1), {8'd5, 9'd5});
    chk("pin_model_65535r", model(16'd65535, 1'b1), {8'd255, 9'd510});

    single(16'd0, 1'b0, 8'd0, 9'd0);
    single(16'd1, 1'b0, 8'd1, 9'd0);
    single(16'd20, 1'b0, 8'd4, 9'd4);
    single(16'd65024, 1'b0, 8'd254, 9'd508);
    single(16'd65535, 1'b0, 8'd255, 9'd510);
    single(16'd20, 1'b1, 8'd4, 9'd4);
    single(16'd21, 1'b1, 8'd5, 9'd5);
    single(16'd65535, 1'b1, 8'd255, 9'd510);

    // Back-to-back stream, alternating round mode.
    repeat (3) @(posedge clk);
    base = n_out;
    #1;
    for (int i = 0; i < 1024; i++) begin
      bus.valor_i = 16'(i);
      bus.round_i = i[0];
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("stream_count", n_out - base, 1024);
    chk("stream_queue_empty", exp_q.size(), 0);

    // Random valid/ready traffic; producer holds an operand until it is taken.
    base = n_out;
    sent = 0;
    acc  = 1'b0;
    @(posedge clk); #1;
    while (sent < 10000) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      if (!bus.valid_i || acc) begin
        if ($urandom_range(0, 99) < 60) begin
          bus.valor_i = 16'($urandom);
          bus.round_i = 1'($urandom);
          bus.valid_i = 1'b1;
        end else begin
          bus.valid_i = 1'b0;
        end
      end
      @(negedge clk);
      acc = bus.valid_i && bus.ready_o;
      if (acc) sent++;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    waitc = 0;
    while ((n_out - base) < 10000 && waitc < 200) begin
      @(posedge clk);
      waitc++;
    end
    @(negedge clk);
    chk("random_count", n_out - base, 10000);
    chk("random_queue_empty", exp_q.size(), 0);

    // Reset with five operands in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.valor_i = 16'(1000 + i * 37);
      bus.round_i = 1'b0;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_valid_o", bus.valid_o, 0);
    chk("flush_ready_o", bus.ready_o, 1);
    repeat (20) @(posedge clk);
    single(16'd144, 1'b0, 8'd12, 9'd0);

    // 32-bit corners.
    single32(32'd0, 16'd0, 17'd0);
    single32(32'hFFFF_FFFF, 16'd65535, 17'd131070);
    single32(32'd4294836225, 16'd65535, 17'd0);
    single32(32'd4294836224, 16'd65534, 17'd131068);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
